ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the instruction substituted on a fetch error.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_addr  output  32  fetch address
- imem_req_ready  input  1  memory accepts request
- imem_rsp_valid  input  1  response valid
- imem_rsp_data  input  32  fetched instruction
- imem_rsp_err  input  1  access fault with response
- redirect_valid  input  1  jump/branch taken
- redirect_pc  input  32  target address
- out_valid  output  1  instruction available to decoder
- out_ready  input  1  decoder consumes instruction
- out_pc  output  32  PC of out_inst
- out_inst  output  32  instruction word
- out_opcode  output  7  out_inst[6:0]
- out_funct3  output  3  out_inst[14:12]
- out_oprand  output  7  out_inst[31:25]
- fetch_err  output  1  out_inst is a substituted NOP due to a fault

Function
REQ-004 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, with at most one outstanding request.
REQ-005 IDLE: SHALL hold all outputs at their reset values and move to REQ unconditionally on the next clock.
REQ-006 REQ: SHALL assert imem_req_valid=1 with imem_req_addr=pc; on imem_req_ready=1, SHALL go to WAIT; otherwise SHALL stay in REQ with addr stable.
REQ-007 WAIT: on imem_rsp_valid=1, SHALL register out_inst=imem_rsp_data, out_pc=pc, fetch_err=imem_rsp_err, and go to HOLD.
REQ-008 On a fault response (imem_rsp_err=1), out_inst SHALL be NOP_INST instead of the response data.
REQ-009 HOLD: SHALL assert out_valid=1 with out_* stable.
REQ-010 HOLD with out_ready=1: SHALL set pc=pc+4 (mod 2^32) and go to REQ.
REQ-011 out_opcode, out_funct3 and out_oprand SHALL be combinational slices of the registered out_inst.
REQ-012 out_valid SHALL be 1 only in HOLD; imem_req_valid SHALL be 1 only in REQ.
REQ-013 Redirect SHALL take priority over every other event in the same cycle, and the target SHALL be pc={redirect_pc[31:2],2'b00}.
REQ-014 Redirect in REQ: the accepted address SHALL be the new pc from the next cycle; a request accepted in the redirect cycle SHALL be treated as stale.
REQ-015 Redirect in WAIT, or in a REQ cycle with imem_req_ready=1: SHALL set a flush flag. The next response SHALL be discarded (no HOLD), the flag SHALL clear, and the FSM SHALL go to REQ.
REQ-016 Response arriving in the same cycle as redirect in WAIT: SHALL be discarded and go directly to REQ, with no flush flag set.
REQ-017 Redirect in HOLD: SHALL drop the held instruction (out_valid=0 next cycle, no handshake even if out_ready=1) and go to REQ.
REQ-018 SHALL ignore imem_rsp_valid outside WAIT, except for consuming the flush flag.
REQ-019 Minimum latency: request accepted at cycle N, response at N+1, out_valid at N+2.
REQ-020 pc wrap: 32'hFFFF_FFFC + 4 SHALL give 32'h0000_0000 with no flag.

Reset
REQ-021 While rst_n=0 (asynchronous assert): state=IDLE, pc=RESET_PC, out_valid=0, imem_req_valid=0, imem_req_addr=0, out_pc=0, out_inst=0, fetch_err=0, flush flag=0.
REQ-022 Reset asserted mid-transaction SHALL abandon it; a response arriving after reset release and before the first request SHALL be ignored.
REQ-023 The first imem_req_valid SHALL occur 2 cycles after rst_n deasserts (IDLE, then REQ).

Verification
REQ-024 Reset release, ready=1, response 32'h00A00093 one cycle later -> out_valid with out_pc=32'h8000_0000, opcode=7'h13, funct3=0, oprand=0; out_ready=1 -> next addr 32'h8000_0004.
REQ-025 imem_req_ready=0 for 3 cycles -> imem_req_valid held with addr unchanged; accept on cycle 4.
REQ-026 Redirect to 32'h8000_0102 during WAIT, then old response 32'hDEADBEEF -> no out_valid; next request addr 32'h8000_0100.
REQ-027 HOLD with out_ready=0 for 5 cycles -> out_* stable; redirect with out_ready=1 in the same cycle -> instruction dropped, fetch from target.
REQ-028 imem_rsp_err=1 -> out_inst=32'h0000_0013, fetch_err=1; consuming it -> pc+4 fetched and fetch_err=0.
REQ-029 Redirect to 32'hFFFF_FFFC, consume -> next addr 32'h0000_0000; rst_n pulse in WAIT -> outputs reset immediately, stale response ignored.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit with redirect and fault handling
//   clk, rst_n                          clock, asynchronous active-low reset
//   imem_req_valid/addr/ready           fetch request channel to instruction memory
//   imem_rsp_valid/data/err             response channel from instruction memory
//   redirect_valid/pc                   taken jump/branch target
//   out_valid/ready/pc/inst             fetched instruction handed to the decoder
//   out_opcode/funct3/oprand            decode fields sliced from out_inst
//   fetch_err                           out_inst is a NOP substituted for a faulting fetch
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_oprand,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        flush_d     = flush_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        fetch_err_d = fetch_err_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect_valid) pc_d = target;
                // a request accepted alongside a redirect fetched the old pc; its response must be dropped
                if (imem_req_ready) begin
                    state_d = WAIT;
                    flush_d = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) pc_d = target;
                if (imem_rsp_valid) begin
                    flush_d = 1'b0;
                    if (flush_q || redirect_valid) begin
                        state_d = REQ;
                    end else begin
                        state_d     = HOLD;
                        out_pc_d    = pc_q;
                        out_inst_d  = imem_rsp_err ? NOP_INST : imem_rsp_data;
                        fetch_err_d = imem_rsp_err;
                    end
                end else if (redirect_valid) begin
                    flush_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (out_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            flush_q     <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_q     <= flush_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = (state_q == REQ) ? pc_q : 32'd0;
    assign out_valid      = (state_q == HOLD);
    assign out_pc         = out_pc_q;
    assign out_inst       = out_inst_q;
    assign fetch_err      = fetch_err_q;
    assign out_opcode     = out_inst_q[6:0];
    assign out_funct3     = out_inst_q[14:12];
    assign out_oprand     = out_inst_q[31:25];
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed-vector bench for ifu_fetch with a transaction-level reference model
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_oprand;
    logic        fetch_err;

    int tests = 0;
    int fails = 0;

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_oprand(out_oprand), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Model: "boot" is the quiet cycle after reset, "req" means a request is on offer,
    // "outs"/"stale" describe the single request in flight, "hold" a delivered instruction.
    typedef struct packed {
        logic        boot, req, outs, stale, hold, herr;
        logic [31:0] pc, hpc, hinst;
    } model_t;

    model_t m;
    localparam model_t M_RESET = '{boot: 1'b1, req: 1'b0, outs: 1'b0, stale: 1'b0, hold: 1'b0, herr: 1'b0,
                                   pc: 32'h8000_0000, hpc: 32'd0, hinst: 32'd0};

    function automatic model_t step(model_t s);
        model_t n = s;
        logic [31:0] tgt = {redirect_pc[31:2], 2'b00};
        if (s.boot) begin
            n.boot = 1'b0;
            n.req  = 1'b1;
        end else if (s.req) begin
            if (redirect_valid) n.pc = tgt;
            if (imem_req_ready) begin
                n.req   = 1'b0;
                n.outs  = 1'b1;
                n.stale = redirect_valid;
            end
        end else if (s.outs) begin
            if (redirect_valid) n.pc = tgt;
            if (imem_rsp_valid) begin
                n.outs  = 1'b0;
                n.stale = 1'b0;
                if (s.stale || redirect_valid) n.req = 1'b1;
                else begin
                    n.hold  = 1'b1;
                    n.hpc   = s.pc;
                    n.hinst = imem_rsp_err ? 32'h0000_0013 : imem_rsp_data;
                    n.herr  = imem_rsp_err;
                end
            end else if (redirect_valid) n.stale = 1'b1;
        end else if (s.hold) begin
            if (redirect_valid || out_ready) begin
                n.hold = 1'b0;
                n.req  = 1'b1;
                n.pc   = redirect_valid ? tgt : s.pc + 32'd4;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= M_RESET;
        else m <= step(m);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, m.req});
        chk("req_addr", imem_req_addr, m.req ? m.pc : 32'd0);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m.hold});
        chk("out_pc", out_pc, m.hpc);
        chk("out_inst", out_inst, m.hinst);
        chk("out_opcode", {25'd0, out_opcode}, {25'd0, m.hinst[6:0]});
        chk("out_funct3", {29'd0, out_funct3}, {29'd0, m.hinst[14:12]});
        chk("out_oprand", {25'd0, out_oprand}, {25'd0, m.hinst[31:25]});
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, m.herr});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd, input logic re,
                         input logic jv, input logic [31:0] jpc, input logic ordy);
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        imem_rsp_err   = re;
        redirect_valid = jv;
        redirect_pc    = jpc;
        out_ready      = ordy;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("lit_reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("lit_reset_addr", imem_req_addr, 32'd0);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("lit_first_req", {31'd0, imem_req_valid}, 32'd1);
        chk("lit_first_addr", imem_req_addr, 32'h8000_0000);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h00A0_0093, 0, 0, 0, 0);
        chk("lit_024_valid", {31'd0, out_valid}, 32'd1);
        chk("lit_024_pc", out_pc, 32'h8000_0000);
        chk("lit_024_opcode", {25'd0, out_opcode}, 32'h13);
        chk("lit_024_funct3", {29'd0, out_funct3}, 32'd0);
        chk("lit_024_oprand", {25'd0, out_oprand}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("lit_024_next_addr", imem_req_addr, 32'h8000_0004);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            chk("lit_025_addr_stable", imem_req_addr, 32'h8000_0004);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h8000_0102, 0);
        drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        chk("lit_026_no_valid", {31'd0, out_valid}, 32'd0);
        chk("lit_026_addr", imem_req_addr, 32'h8000_0100);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h0010_0113, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0, 0);
        chk("lit_027_held_pc", out_pc, 32'h8000_0100);
        drive(0, 0, 0, 0, 1, 32'h8000_0200, 1);
        chk("lit_027_dropped", {31'd0, out_valid}, 32'd0);
        chk("lit_027_addr", imem_req_addr, 32'h8000_0200);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h1234_5678, 1, 0, 0, 0);
        chk("lit_028_nop", out_inst, 32'h0000_0013);
        chk("lit_028_err", {31'd0, fetch_err}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("lit_028_next_addr", imem_req_addr, 32'h8000_0204);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h0000_0033, 0, 0, 0, 0);
        chk("lit_028_err_clear", {31'd0, fetch_err}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'hAAAA_AAAA, 0, 1, 32'h8000_0300, 0);
        chk("lit_016_no_valid", {31'd0, out_valid}, 32'd0);
        chk("lit_016_addr", imem_req_addr, 32'h8000_0300);
        drive(1, 0, 0, 0, 1, 32'h8000_0401, 0);
        drive(0, 1, 32'hBBBB_BBBB, 0, 0, 0, 0);
        chk("lit_015_no_valid", {31'd0, out_valid}, 32'd0);
        chk("lit_015_addr", imem_req_addr, 32'h8000_0400);
        drive(0, 0, 0, 0, 1, 32'h8000_0500, 0);
        chk("lit_014_addr", imem_req_addr, 32'h8000_0500);
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h0000_0073, 0, 0, 0, 0);
        chk("lit_029_pc", out_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("lit_029_wrap", imem_req_addr, 32'h0000_0000);
        drive(1, 0, 0, 0, 0, 0, 0);
        imem_req_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("lit_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("lit_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("lit_rst_out_pc", out_pc, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(0, 1, 32'hCCCC_CCCC, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lit_022_ignored", {31'd0, out_valid}, 32'd0);
        chk("lit_022_addr", imem_req_addr, 32'h8000_0000);
        drive(0, 0, 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
